// File: rtl/riscv_run_ctrl_g7.sv
// riscv_run_ctrl_g7: holds core_rst for RST_CYCLES, counts RUN cycles/retires, latches tohost pass/fail or timeout verdict; restart re-runs from DONE
module riscv_run_ctrl_g7 #(
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 20,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              retire_valid,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [DATA_W-2:0] exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(MAX_CYCLES - 1);
  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [HW-1:0] r_hold;
  logic [CNT_W-1:0] r_cycle, r_instret;
  logic [DATA_W-2:0] r_code;
  logic r_pass, r_fail, r_timeout;
  logic w_exit, w_timeout;
  assign w_exit = wr_valid && wr_addr == TOHOST_ADDR && wr_data[0];
  assign w_timeout = MAX_CYCLES != 0 && r_cycle == RUN_LAST;
  always_comb begin
    w_next = r_state;
    w_next = r_state == S_HOLD ? (r_hold == HOLD_LAST ? S_RUN : S_HOLD) :
             r_state == S_RUN  ? (w_exit || w_timeout ? S_DONE : S_RUN) :
             (restart ? S_HOLD : S_DONE);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_HOLD;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_hold <= '0;
      r_cycle <= '0;
      r_instret <= '0;
      r_code <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_timeout <= 1'b0;
    end else if (r_state == S_HOLD) begin
      r_hold <= r_hold + HW'(1);
    end else if (r_state == S_RUN) begin
      r_cycle <= r_cycle + CNT_W'(~&r_cycle);
      r_instret <= r_instret + CNT_W'(retire_valid && ~&r_instret);
      if (w_exit) begin
        r_pass <= wr_data == DATA_W'(1);
        r_fail <= wr_data != DATA_W'(1);
        r_code <= wr_data[DATA_W-1:1];
      end else begin
        r_timeout <= w_timeout;
      end
    end else if (restart) begin
      r_hold <= '0;
      r_cycle <= '0;
      r_instret <= '0;
      r_code <= '0;
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      r_timeout <= 1'b0;
    end
  assign core_rst = r_state != S_RUN;
  assign running = r_state == S_RUN;
  assign done = r_state == S_DONE;
  assign pass = r_pass;
  assign fail = r_fail;
  assign timeout = r_timeout;
  assign exit_code = r_code;
  assign cycle_count = r_cycle;
  assign instret_count = r_instret;
endmodule

// File: tb/tb_riscv_run_ctrl_g7.sv
// tb_riscv_run_ctrl_g7: randomized runs scored against a per-run verdict model, plus hold timing, restart, async reset and no-timeout checks
module tb_riscv_run_ctrl_g7;
  localparam int RC = 2;
  localparam int MC = 20;
  localparam logic [31:0] TOHOST = 32'h0000_1000;
  typedef struct {
    logic p, f, t;
    logic [30:0] code;
    logic [31:0] cyc, ins;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, rst0 = 1'b1, restart = 1'b0, wr_valid = 1'b0, retire_valid = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic core_rst, running, done, pass, fail, timeout;
  logic [30:0] exit_code;
  logic [31:0] cycle_count, instret_count;
  logic core_rst0, running0, done0, pass0, fail0, timeout0;
  logic [30:0] exit_code0;
  logic [31:0] cycle_count0, instret_count0;
  exp_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic prev_done = 1'b0;
  always #5 clk = ~clk;
  riscv_run_ctrl_g7 #(.RST_CYCLES(RC), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .restart(restart), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .retire_valid(retire_valid), .core_rst(core_rst), .running(running),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .exit_code(exit_code),
    .cycle_count(cycle_count), .instret_count(instret_count));
  riscv_run_ctrl_g7 #(.RST_CYCLES(RC), .MAX_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst0), .restart(1'b0), .wr_valid(1'b0), .wr_addr(wr_addr),
    .wr_data(wr_data), .retire_valid(retire_valid), .core_rst(core_rst0), .running(running0),
    .done(done0), .pass(pass0), .fail(fail0), .timeout(timeout0), .exit_code(exit_code0),
    .cycle_count(cycle_count0), .instret_count(instret_count0));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (done) chk("verdict_onehot", 64'(pass) + 64'(fail) + 64'(timeout), 1);
    else chk("verdict_clear", {pass, fail, timeout}, 0);
    if (done && !prev_done) begin
      chk("pending_expectation", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pass", pass, e.p);
        chk("fail", fail, e.f);
        chk("timeout", timeout, e.t);
        chk("exit_code", exit_code, e.code);
        chk("cycle_count", cycle_count, e.cyc);
        chk("instret_count", instret_count, e.ins);
        chk("core_rst_in_done", core_rst, 1);
        chk("running_in_done", running, 0);
      end
    end
    prev_done = done;
  end
  task automatic check_hold(input string nm);
    repeat (RC - 1) @(posedge clk);
    @(negedge clk);
    chk({nm, "_core_rst_held"}, core_rst, 1);
    chk({nm, "_not_running_yet"}, running, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_core_rst_released"}, core_rst, 0);
    chk({nm, "_running"}, running, 1);
    chk({nm, "_cycle_start"}, cycle_count, 0);
  endtask
  task automatic do_run(input int ex, input logic [31:0] d, input bit all_ret, input bit hit_rst);
    bit ret[$];
    int len;
    bit r, is_exit;
    exp_t e;
    len = (ex >= 0 && ex < MC) ? ex + 1 : MC;
    is_exit = ex >= 0 && ex < MC;
    e.ins = 0;
    for (int k = 0; k < len; k++) begin
      r = all_ret ? 1'b1 : 1'($urandom_range(0, 1));
      ret.push_back(r);
      e.ins += 32'(r);
    end
    e.cyc = len;
    e.p = is_exit && d == 1;
    e.f = is_exit && d != 1;
    e.t = !is_exit;
    e.code = is_exit ? d[31:1] : '0;
    if (!hit_rst) exp_q.push_back(e);
    for (int k = 0; k < len; k++) begin
      if (hit_rst && k == len / 2) begin
        #2 rst = 1'b1;
        #1;
        chk("async_core_rst", core_rst, 1);
        chk("async_running", running, 0);
        chk("async_cycle_count", cycle_count, 0);
        chk("async_instret_count", instret_count, 0);
        @(negedge clk);
        rst = 1'b0;
        wr_valid = 1'b0;
        restart = 1'b0;
        check_hold("after_async_rst");
        return;
      end
      retire_valid = ret[k];
      if (k == ex) begin
        wr_valid = 1'b1; wr_addr = TOHOST; wr_data = d;
      end else if (k == 1) begin
        wr_valid = 1'b1; wr_addr = TOHOST; wr_data = 32'h6;
      end else if (k == 2) begin
        wr_valid = 1'b1; wr_addr = TOHOST + 32'h4; wr_data = 32'h1;
      end else begin
        wr_valid = $urandom_range(0, 2) == 0;
        wr_addr = $urandom_range(0, 1) == 1 ? TOHOST : TOHOST + 32'(4 * $urandom_range(1, 100));
        wr_data = $urandom;
        if (wr_addr == TOHOST) wr_data[0] = 1'b0;
      end
      restart = $urandom_range(0, 7) == 0;
      @(negedge clk);
    end
    restart = 1'b0;
    repeat (3) begin
      wr_valid = 1'b1; wr_addr = TOHOST; wr_data = 32'h1; retire_valid = 1'b1;
      @(negedge clk);
    end
    chk("done_held", done, 1);
    chk("cycle_count_frozen", cycle_count, e.cyc);
    chk("instret_frozen", instret_count, e.ins);
    chk("exit_code_frozen", exit_code, e.code);
    wr_valid = 1'b0; retire_valid = 1'b0; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart_done", done, 0);
    chk("restart_cycle", cycle_count, 0);
    chk("restart_instret", instret_count, 0);
    chk("restart_code", exit_code, 0);
    chk("restart_core_rst", core_rst, 1);
    check_hold("after_restart");
  endtask
  initial begin
    int n;
    logic [31:0] d;
    #2;
    chk("rst_core_rst", core_rst, 1);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_cycle", cycle_count, 0);
    chk("rst_instret", instret_count, 0);
    chk("rst_code", exit_code, 0);
    #18 rst = 1'b0;
    check_hold("boot");
    do_run(7, 32'h1, 1'b1, 1'b0);
    do_run(5, 32'h7, 1'b0, 1'b0);
    do_run(-1, 32'h0, 1'b0, 1'b0);
    do_run(19, 32'h1, 1'b0, 1'b0);
    do_run(-1, 32'h0, 1'b0, 1'b1);
    repeat (10) begin
      d = $urandom_range(0, 2) == 0 ? 32'h1 : ($urandom | 32'h1);
      do_run($urandom_range(0, 24), d, 1'b0, 1'b0);
    end
    rst = 1'b1;
    wr_valid = 1'b0;
    retire_valid = 1'b0;
    @(negedge clk);
    rst0 = 1'b0;
    repeat (RC) @(negedge clk);
    chk("nto_running", running0, 1);
    n = 0;
    repeat (1000) begin
      retire_valid = 1'($urandom_range(0, 1));
      n += int'(retire_valid);
      @(negedge clk);
    end
    chk("nto_still_running", running0, 1);
    chk("nto_no_timeout", timeout0, 0);
    chk("nto_not_done", done0, 0);
    chk("nto_cycle_count", cycle_count0, 1000);
    chk("nto_instret", instret_count0, 32'(n));
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
